// File: rtl/pid_pkg.sv
// Shared definitions for the PID move sequencer and its neighbours (pid_control datapath,
// host command logic): FSM state encodings, percent limits, default deadband and the
// layout of one queued move command.
package pid_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_MOVE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT = 3'd4;

  // Control effort range in millipercent (+/-100.000%).
  localparam int PCT_MAX          = 100000;
  localparam int PCT_MIN          = -100000;
  localparam int DEADBAND_DEFAULT = 13000;

  // One queued move: timeout in servo updates (0 = none) above the signed target.
  typedef struct packed {
    logic        [15:0] timeout;
    logic signed [31:0] target;
  } move_cmd_t;

  localparam int MOVE_CMD_W = $bits(move_cmd_t);

endpackage

// File: rtl/move_cmd_fifo.sv
// Synchronous FIFO holding queued move commands.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   flush          empties the queue next cycle; overrides push and pop
//   push / pop     write / read strobes (ignored when full / empty)
//   wr_data        entry to write
//   rd_data        head entry (show-ahead, valid whenever empty is 0)
//   full / empty   occupancy flags
module move_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full queue refuses a push even if the head is popped in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pid_move_sequencer.sv
// Sequences one linear-actuator PID loop through queued move commands.
// Generates the servo update strobe, slews the PID setpoint toward each target, gates and
// deadbands the PID output to the motor, and reports settle-done or timeout-fault per move.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   cmd_valid/ready     move command handshake (ready = queue not full)
//   cmd_target          signed target position, micrometres
//   cmd_timeout         timeout in servo updates, 0 = none
//   abort               flush queue and stop the current move
//   feedback            signed actuator position, micrometres
//   pid_control         signed PID output, millipercent
//   pid_tick            one-cycle servo update strobe
//   pid_setpoint        signed slewed setpoint to the PID stage
//   motor_cmd           signed gated motor command, millipercent (1-cycle latency)
//   busy                move in progress (LOAD/MOVE)
//   done / fault        one-cycle pulses: move settled / move timed out
module pid_move_sequencer
  import pid_pkg::*;
#(
  parameter int UPDATE_DIV   = 10_000_000,
  parameter int FIFO_DEPTH   = 4,
  parameter int STEP_MAX     = 1700,
  parameter int SETTLE_TOL   = 1000,
  parameter int SETTLE_TICKS = 3,
  parameter int DEADBAND     = DEADBAND_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_target,
  input  logic [15:0] cmd_timeout,
  input  logic        abort,
  input  logic [31:0] feedback,
  input  logic [31:0] pid_control,
  output logic        pid_tick,
  output logic [31:0] pid_setpoint,
  output logic [31:0] motor_cmd,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int DIV_W = $clog2(UPDATE_DIV);
  localparam int SW    = $clog2(SETTLE_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic signed [32:0] STEP_LIM = 33'(STEP_MAX);
  localparam logic [32:0]        TOL33    = 33'(SETTLE_TOL);
  localparam logic [32:0]        DB33     = 33'(DEADBAND);

  // Clamp the distance to target into one update's worth of travel. The difference is
  // formed in 33 bits so opposite-sign extremes cannot wrap; the clamped result always
  // lies between 0 and the true difference, so it fits back in 32 bits.
  function automatic logic signed [31:0] slew_step(input logic signed [31:0] tgt,
                                                   input logic signed [31:0] cur);
    logic signed [32:0] diff;
    logic signed [32:0] lim;
    diff = {tgt[31], tgt} - {cur[31], cur};
    if (diff > STEP_LIM)       lim = STEP_LIM;
    else if (diff < -STEP_LIM) lim = -STEP_LIM;
    else                       lim = diff;
    return 32'(lim);
  endfunction

  // Magnitude of a 33-bit signed value; the most negative input maps to 2^32 exactly.
  function automatic logic [32:0] mag33(input logic signed [32:0] v);
    return v[32] ? 33'(-v) : 33'(v);
  endfunction

  // Small control efforts cannot overcome stiction, so they are zeroed.
  function automatic logic signed [31:0] deadband_gate(input logic signed [31:0] v);
    return (mag33({v[31], v}) < DB33) ? 32'sd0 : v;
  endfunction

  logic [DIV_W-1:0]   div_cnt;
  logic [STATE_W-1:0] state;
  logic signed [31:0] target_q;
  logic [15:0]        timeout_q;
  logic signed [31:0] setpoint_q;
  logic [15:0]        tick_cnt;
  logic [SW-1:0]      settle_cnt;
  logic signed [31:0] motor_cmd_p1;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [MOVE_CMD_W-1:0] fifo_rd_data;
  move_cmd_t          head;

  logic signed [31:0] sp_next;
  logic [15:0]        tick_next;
  logic signed [32:0] err33;
  logic [SW-1:0]      settle_next;
  logic               settled;
  logic               timed_out;

  // Servo update divider: free-running in every state, untouched by abort.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pid_tick = (div_cnt == DIV_LAST);

  // Command queue: abort flushes it and drops any offer in the same cycle.
  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !abort;
  assign head      = move_cmd_t'(fifo_rd_data);

  move_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MOVE_CMD_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (abort),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({cmd_timeout, cmd_target}),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Per-update arithmetic for the MOVE state.
  always_comb begin
    sp_next     = setpoint_q + slew_step(target_q, setpoint_q);
    tick_next   = (tick_cnt == 16'hFFFF) ? tick_cnt : tick_cnt + 16'd1;
    err33       = {target_q[31], target_q} - {feedback[31], feedback};
    settle_next = (mag33(err33) <= TOL33) ? settle_cnt + SW'(1) : '0;
    settled     = (settle_next == SW'(SETTLE_TICKS));
    timed_out   = (timeout_q != 16'd0) && (tick_next == timeout_q);
  end

  // The head is consumed by the pop, so the move parameters are captured on that edge.
  always_ff @(posedge clock) begin
    if (fifo_pop) begin
      target_q  <= head.target;
      timeout_q <= head.timeout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      setpoint_q <= '0;
      tick_cnt   <= '0;
      settle_cnt <= '0;
    end else if (abort) begin
      state      <= ST_IDLE;
      setpoint_q <= feedback;
    end else begin
      case (state)
        ST_IDLE: begin
          setpoint_q <= feedback;
          if (!fifo_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          setpoint_q <= feedback;
          tick_cnt   <= '0;
          settle_cnt <= '0;
          state      <= ST_MOVE;
        end
        ST_MOVE: begin
          if (pid_tick) begin
            setpoint_q <= sp_next;
            tick_cnt   <= tick_next;
            settle_cnt <= settle_next;
            // Settling on the same update as the timeout counts as success.
            if (settled)        state <= ST_DONE;
            else if (timed_out) state <= ST_FAULT;
          end
        end
        ST_DONE, ST_FAULT: state <= ST_IDLE;
        default:           state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: registered motor command ----
  always_ff @(posedge clock) begin
    if (reset || abort || (state != ST_MOVE)) begin
      motor_cmd_p1 <= '0;
    end else begin
      motor_cmd_p1 <= deadband_gate(pid_control);
    end
  end

  assign motor_cmd    = motor_cmd_p1;
  assign pid_setpoint = setpoint_q;
  assign busy         = (state == ST_LOAD) || (state == ST_MOVE);
  assign done         = (state == ST_DONE);
  assign fault        = (state == ST_FAULT);

endmodule

// File: tb/tb_pid_move_sequencer.sv
module tb_pid_move_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_target;
  logic [15:0] cmd_timeout;
  logic        abort;
  logic [31:0] feedback;
  logic [31:0] pid_control;
  logic        pid_tick;
  logic [31:0] pid_setpoint;
  logic [31:0] motor_cmd;
  logic        busy;
  logic        done;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;

  logic signed [31:0] sp_q[$];
  logic [1:0]         evt_q[$];

  always #5 clock = ~clock;

  pid_move_sequencer #(
    .UPDATE_DIV   (10),
    .FIFO_DEPTH   (4),
    .STEP_MAX     (1700),
    .SETTLE_TOL   (1000),
    .SETTLE_TICKS (3),
    .DEADBAND     (13000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .cmd_timeout  (cmd_timeout),
    .abort        (abort),
    .feedback     (feedback),
    .pid_control  (pid_control),
    .pid_tick     (pid_tick),
    .pid_setpoint (pid_setpoint),
    .motor_cmd    (motor_cmd),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input int tgt, input int to);
    cmd_valid   = 1'b1;
    cmd_target  = tgt;
    cmd_timeout = 16'(to);
    cyc();
    cmd_valid   = 1'b0;
  endtask

  // Returns at the falling edge of a cycle in which pid_tick is high.
  task automatic wait_tick(input string tag);
    int n = 0;
    while (pid_tick !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk1({tag, "_tick"}, pid_tick, 1'b1);
  endtask

  // Waits for LOAD, then steps into MOVE.
  task automatic wait_move(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk1({tag, "_busy"}, busy, 1'b1);
    cyc();
  endtask

  task automatic chk_sp(input string tag);
    logic signed [31:0] e;
    e = (sp_q.size() != 0) ? sp_q.pop_front() : 32'sh7FFF_FFFF;
    chk32(tag, pid_setpoint, e);
  endtask

  task automatic chk_evt(input string tag);
    logic [1:0] e;
    e = (evt_q.size() != 0) ? evt_q.pop_front() : 2'b11;
    chk32(tag, 32'({done, fault}), 32'(e));
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_target  = '0;
    cmd_timeout = '0;
    abort       = 1'b0;
    feedback    = 32'd777;
    pid_control = '0;

    // Reset state and divider phase
    repeat (3) @(posedge clock);
    cyc();
    chk1("rst_tick", pid_tick, 1'b0);
    chk32("rst_sp", pid_setpoint, 32'd0);
    chk32("rst_motor", motor_cmd, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    reset = 1'b0;
    cyc();
    chk1("ready_after_rst", cmd_ready, 1'b1);
    chk32("idle_track_fb", pid_setpoint, 32'd777);
    chk1("tick_phase_1", pid_tick, 1'b0);
    for (int i = 2; i <= 9; i++) begin
      cyc();
      chk1("tick_phase", pid_tick, (i == 9));
    end

    // Slew toward 5000 with feedback held at 0, then deadband gating in MOVE
    feedback = 32'd0;
    sp_q.push_back(32'sd1700);
    sp_q.push_back(32'sd3400);
    sp_q.push_back(32'sd5000);
    sp_q.push_back(32'sd5000);
    push_cmd(5000, 0);
    wait_move("slew");
    for (int t = 0; t < 4; t++) begin
      wait_tick("slew");
      cyc();
      chk_sp("slew_sp");
      chk1("slew_busy", busy, 1'b1);
    end
    pid_control = 32'sd12999;
    cyc();
    chk32("db_inside", motor_cmd, 32'd0);
    pid_control = -32'sd13000;
    cyc();
    chk32("db_edge_neg", motor_cmd, -32'sd13000);
    pid_control = 32'sd13000;
    cyc();
    chk32("db_edge_pos", motor_cmd, 32'sd13000);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk1("abort1_busy", busy, 1'b0);
    chk32("abort1_motor", motor_cmd, 32'd0);
    chk32("abort1_pulse", 32'({done, fault}), 32'd0);
    pid_control = 32'sd50000;
    cyc();
    cyc();
    chk32("idle_motor", motor_cmd, 32'd0);

    // Settle: feedback within tolerance from the first update
    feedback = 32'sd4500;
    evt_q.push_back(2'b10);
    push_cmd(5000, 0);
    wait_move("settle");
    for (int t = 1; t <= 2; t++) begin
      wait_tick("settle");
      cyc();
      chk1("settle_nodone", done, 1'b0);
      chk1("settle_busy", busy, 1'b1);
      if (t == 1) begin
        chk32("settle_sp", pid_setpoint, 32'sd5000);
        chk32("move_motor", motor_cmd, 32'sd50000);
      end
    end
    wait_tick("settle");
    cyc();
    chk_evt("settle_evt");
    chk1("settle_busy_fall", busy, 1'b0);
    cyc();
    chk1("settle_done_1cyc", done, 1'b0);
    chk32("settle_motor", motor_cmd, 32'd0);

    // Timeout after 5 updates, then the queued move runs and settles
    feedback    = 32'd0;
    pid_control = 32'd0;
    evt_q.push_back(2'b01);
    evt_q.push_back(2'b10);
    sp_q.push_back(32'sd1700);
    sp_q.push_back(32'sd3400);
    sp_q.push_back(32'sd5100);
    sp_q.push_back(32'sd6800);
    sp_q.push_back(32'sd8500);
    sp_q.push_back(32'sd100);
    push_cmd(900000, 5);
    push_cmd(100, 0);
    wait_move("tmo");
    for (int t = 1; t <= 5; t++) begin
      wait_tick("tmo");
      cyc();
      chk_sp("tmo_sp");
      if (t < 5) chk32("tmo_nopulse", 32'({done, fault}), 32'd0);
    end
    chk_evt("tmo_evt");
    cyc();
    chk1("tmo_idle", busy, 1'b0);
    cyc();
    chk1("next_load", busy, 1'b1);
    wait_move("next");
    for (int t = 1; t <= 3; t++) begin
      wait_tick("next");
      cyc();
      if (t == 1) chk_sp("next_sp");
      if (t < 3) chk1("next_nodone", done, 1'b0);
    end
    chk_evt("next_evt");

    // Queue fills while a move is running; abort flushes it
    pid_control = 32'sd50000;
    push_cmd(900000, 0);
    wait_move("fill");
    for (int i = 0; i < 5; i++) begin
      chk1("fill_ready", cmd_ready, (i < 4));
      cmd_valid  = 1'b1;
      cmd_target = i;
      cyc();
    end
    cmd_valid = 1'b0;
    chk32("fill_motor", motor_cmd, 32'sd50000);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk1("abort2_busy", busy, 1'b0);
    chk32("abort2_motor", motor_cmd, 32'd0);
    chk32("abort2_pulse", 32'({done, fault}), 32'd0);
    chk1("abort2_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("abort2_empty", busy, 1'b0);
    end
    // An offer coincident with abort is dropped
    cmd_valid  = 1'b1;
    cmd_target = 32'd5;
    abort      = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("abort_drop", busy, 1'b0);
    end

    // Reset in the middle of a move
    push_cmd(900000, 0);
    wait_move("rstmv");
    reset = 1'b1;
    cyc();
    chk1("rstmv_busy", busy, 1'b0);
    chk32("rstmv_sp", pid_setpoint, 32'd0);
    chk32("rstmv_motor", motor_cmd, 32'd0);
    chk32("rstmv_pulse", 32'({done, fault}), 32'd0);
    reset = 1'b0;
    cyc();
    chk1("rstmv_idle", busy, 1'b0);
    chk32("rstmv_pulse2", 32'({done, fault}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
